// File: rtl/sprite_draw_scheduler_pkg.sv
// draw_pkg: scheduler state encoding and default sprite/screen geometry shared by the draw path.
package draw_pkg;
    typedef enum logic [2:0] {IDLE, SELECT, ERASE, DRAW, NEXT, DONE} state_t;
    localparam int OBJ_IDX_W     = 4;
    localparam int DEF_SPR_W     = 8;
    localparam int DEF_SPR_H     = 8;
    localparam int DEF_SCREEN_W  = 160;
    localparam int DEF_SCREEN_H  = 120;
    localparam int DEF_BG_COLOR  = 0;
endpackage

// File: rtl/sprite_draw_scheduler_if.sv
// sprite_draw_scheduler_if: valid/ready pixel-plot port between the scheduler and the VGA adapter.
interface sprite_draw_scheduler_if #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3
);
    logic               plot_valid;
    logic               plot_ready;
    logic [X_W-1:0]     plot_x;
    logic [Y_W-1:0]     plot_y;
    logic [COLOR_W-1:0] plot_color;
    modport master (output plot_valid, plot_x, plot_y, plot_color, input plot_ready);
    modport slave (input plot_valid, plot_x, plot_y, plot_color, output plot_ready);
endinterface

// File: rtl/sprite_draw_scheduler_scanner.sv
// sprite_pixel_scanner: raster-scans one sprite through a valid/ready pixel port.
// With DRAW_CLIP_EN defined, off-screen pixels are skipped in one cycle without asserting valid.
module sprite_pixel_scanner
    import draw_pkg::*;
#(
    parameter int SPR_W    = DEF_SPR_W,
    parameter int SPR_H    = DEF_SPR_H,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOR_W  = 3,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [X_W-1:0]     base_x,
    input  logic [Y_W-1:0]     base_y,
    input  logic [COLOR_W-1:0] color,
    input  logic               ready,
    output logic               valid,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               last
);
    localparam int PX_W = SPR_W > 1 ? $clog2(SPR_W) : 1;
    localparam int PY_W = SPR_H > 1 ? $clog2(SPR_H) : 1;

    logic            active, vis, adv, px_end, py_end, in_screen;
    logic [PX_W-1:0] px;
    logic [PY_W-1:0] py;
    logic [X_W:0]    sx;
    logic [Y_W:0]    sy;

    assign sx        = {1'b0, base_x} + (X_W+1)'(px);
    assign sy        = {1'b0, base_y} + (Y_W+1)'(py);
    assign in_screen = sx < (X_W+1)'(SCREEN_W) && sy < (Y_W+1)'(SCREEN_H);
`ifdef DRAW_CLIP_EN
    assign vis = in_screen;
`else
    logic unused_clip;
    assign unused_clip = in_screen;
    assign vis         = 1'b1;
`endif
    assign valid     = active && vis;
    assign adv       = active && (ready || !vis);
    assign px_end    = px == PX_W'(SPR_W - 1);
    assign py_end    = py == PY_W'(SPR_H - 1);
    assign last      = adv && px_end && py_end;
    assign x         = sx[X_W-1:0];
    assign y         = sy[Y_W-1:0];
    assign pix_color = color;

    // start wins over last so an erase can hand straight over to its draw scan
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            px     <= '0;
            py     <= '0;
        end else if (start) begin
            active <= 1'b1;
            px     <= '0;
            py     <= '0;
        end else if (adv) begin
            px     <= px_end ? '0 : px + 1'b1;
            py     <= px_end ? (py_end ? '0 : py + 1'b1) : py;
            active <= !last;
        end
    end
endmodule

// File: rtl/sprite_draw_scheduler.sv
// sprite_draw_scheduler: per-frame erase/redraw of every object through one shared pixel-plot port.
// Clipping is compiled in with DRAW_CLIP_EN (inside sprite_pixel_scanner).
module sprite_draw_scheduler
    import draw_pkg::*;
#(
    parameter int NUM_OBJ  = 6,
    parameter int SPR_W    = DEF_SPR_W,
    parameter int SPR_H    = DEF_SPR_H,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOR_W  = 3,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int BG_COLOR = DEF_BG_COLOR
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_tick,
    input  logic [NUM_OBJ-1:0]         obj_active,
    input  logic [NUM_OBJ*X_W-1:0]     obj_x,
    input  logic [NUM_OBJ*Y_W-1:0]     obj_y,
    input  logic [NUM_OBJ*COLOR_W-1:0] obj_color,
    sprite_draw_scheduler_if.master    plot,
    output logic [OBJ_IDX_W-1:0]       cur_obj,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overrun
);
    localparam int IDX_W = $clog2(NUM_OBJ);

    state_t               state, state_n;
    logic [OBJ_IDX_W-1:0] obj_i, obj_n;
    logic [IDX_W-1:0]     idx;
    logic [NUM_OBJ-1:0]   snap_active, prev_active;
    logic [X_W-1:0]       snap_x [NUM_OBJ];
    logic [X_W-1:0]       prev_x [NUM_OBJ];
    logic [Y_W-1:0]       snap_y [NUM_OBJ];
    logic [Y_W-1:0]       prev_y [NUM_OBJ];
    logic [COLOR_W-1:0]   snap_color [NUM_OBJ];
    logic                 start, last, erasing, final_obj;

    assign idx        = IDX_W'(obj_i);
    assign erasing    = state == ERASE;
    assign final_obj  = obj_i == OBJ_IDX_W'(NUM_OBJ - 1);
    assign cur_obj    = obj_i;
    assign busy       = state inside {SELECT, ERASE, DRAW, NEXT};
    assign frame_done = state == DONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            obj_i <= '0;
        end else begin
            state <= state_n;
            obj_i <= obj_n;
        end
    end

    always_comb begin
        state_n = state;
        obj_n   = obj_i;
        start   = 1'b0;
        case (state)
            IDLE: begin
                state_n = frame_tick ? SELECT : IDLE;
                obj_n   = '0;
            end
            SELECT: begin
                state_n = prev_active[idx] ? ERASE : snap_active[idx] ? DRAW : NEXT;
                start   = prev_active[idx] || snap_active[idx];
            end
            ERASE: if (last) begin
                state_n = snap_active[idx] ? DRAW : NEXT;
                start   = snap_active[idx];
            end
            DRAW: state_n = last ? NEXT : DRAW;
            NEXT: begin
                state_n = final_obj ? DONE : SELECT;
                obj_n   = final_obj ? obj_i : obj_i + 1'b1;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // snapshot at the tick and the previous-frame table committed per object in NEXT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun     <= 1'b0;
            snap_active <= '0;
            prev_active <= '0;
            for (int k = 0; k < NUM_OBJ; k++) begin
                snap_x[k]     <= '0;
                snap_y[k]     <= '0;
                snap_color[k] <= '0;
                prev_x[k]     <= '0;
                prev_y[k]     <= '0;
            end
        end else begin
            overrun <= frame_tick && state != IDLE;
            if (state == IDLE && frame_tick) begin
                snap_active <= obj_active;
                for (int k = 0; k < NUM_OBJ; k++) begin
                    snap_x[k]     <= obj_x[k*X_W +: X_W];
                    snap_y[k]     <= obj_y[k*Y_W +: Y_W];
                    snap_color[k] <= obj_color[k*COLOR_W +: COLOR_W];
                end
            end
            if (state == NEXT) begin
                prev_active[idx] <= snap_active[idx];
                prev_x[idx]      <= snap_x[idx];
                prev_y[idx]      <= snap_y[idx];
            end
        end
    end

    sprite_pixel_scanner #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W),
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
    ) u_scan (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_x    (erasing ? prev_x[idx] : snap_x[idx]),
        .base_y    (erasing ? prev_y[idx] : snap_y[idx]),
        .color     (erasing ? COLOR_W'(BG_COLOR) : snap_color[idx]),
        .ready     (plot.plot_ready),
        .valid     (plot.plot_valid),
        .x         (plot.plot_x),
        .y         (plot.plot_y),
        .pix_color (plot.plot_color),
        .last      (last)
    );
endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// tb_sprite_draw_scheduler: directed and randomized frames checked against a pixel-list model.
module tb_sprite_draw_scheduler;
    import draw_pkg::*;
    localparam int N    = 6;
    localparam int XW   = 8;
    localparam int YW   = 7;
    localparam int CW   = 3;
    localparam int NPIX = DEF_SPR_W * DEF_SPR_H;

    typedef struct {int x; int y; int c;} pix_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            frame_tick = 1'b0;
    logic [N-1:0]    obj_active = '0;
    logic [N*XW-1:0] obj_x = '0;
    logic [N*YW-1:0] obj_y = '0;
    logic [N*CW-1:0] obj_color = '0;
    logic [OBJ_IDX_W-1:0] cur_obj;
    logic            busy, frame_done, overrun;
    int              checks = 0;
    int              errors = 0;
    pix_t            exp_q[$];
    int              m_act[N];
    int              m_x[N];
    int              m_y[N];
    int              m_len;

    sprite_draw_scheduler_if #(.X_W(XW), .Y_W(YW), .COLOR_W(CW)) plot ();

    sprite_draw_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .obj_active (obj_active),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .obj_color  (obj_color),
        .plot       (plot),
        .cur_obj    (cur_obj),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_obj(input int o, input int x, input int y, input int c);
        obj_x[o*XW +: XW] = XW'(x);
        obj_y[o*YW +: YW] = YW'(y);
        obj_color[o*CW +: CW] = CW'(c);
    endtask

    task automatic randomize_objs();
        obj_active = N'($urandom);
        for (int o = 0; o < N; o++) set_obj(o, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), int'($urandom_range(0, 7)));
    endtask

    // every sprite is a raster of (base+px, base+py), px fastest, optionally dropping off-screen pixels
    task automatic add_sprite(input int bx, input int by, input int c);
        pix_t p;
        for (int py = 0; py < DEF_SPR_H; py++)
            for (int px = 0; px < DEF_SPR_W; px++) begin
`ifdef DRAW_CLIP_EN
                if (bx + px >= DEF_SCREEN_W || by + py >= DEF_SCREEN_H) continue;
`endif
                p.x = (bx + px) % (1 << XW);
                p.y = (by + py) % (1 << YW);
                p.c = c;
                exp_q.push_back(p);
            end
        m_len += NPIX;
    endtask

    task automatic build_expected();
        m_len = 2 * N + 1;
        for (int o = 0; o < N; o++) begin
            if (m_act[o] != 0) add_sprite(m_x[o], m_y[o], 0);
            if (obj_active[o]) add_sprite(int'(obj_x[o*XW +: XW]), int'(obj_y[o*YW +: YW]), int'(obj_color[o*CW +: CW]));
            m_act[o] = int'(obj_active[o]);
            m_x[o] = int'(obj_x[o*XW +: XW]);
            m_y[o] = int'(obj_y[o*YW +: YW]);
        end
    endtask

    task automatic run_frame(input bit rnd, input bit poke);
        int k = 0;
        int done_k = 0;
        int dones = 0;
        int ovrs = 0;
        bit stalled = 1'b0;
        logic [31:0] held = '0;
        pix_t e;
        build_expected();
        frame_tick = 1'b1;
        plot.plot_ready = 1'b1;
        while (k < 6000 && (dones == 0 || k < done_k + 3)) begin
            @(negedge clk);
            k++;
            ovrs += int'(overrun);
            if (k == 1) begin
                chk("busy_after_tick", 32'(busy), 1);
                chk("no_valid_in_select", 32'(plot.plot_valid), 0);
            end
            if (stalled) chk("stall_hold", 32'({plot.plot_valid, plot.plot_x, plot.plot_y, plot.plot_color}), held);
            if (frame_done) begin
                dones++;
                if (dones == 1) begin
                    done_k = k;
                    chk("busy_low_at_done", 32'(busy), 0);
                end
            end
            frame_tick = poke && k == 3;
            if (k == 1) randomize_objs();
            plot.plot_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = plot.plot_valid && !plot.plot_ready;
            held = 32'({plot.plot_valid, plot.plot_x, plot.plot_y, plot.plot_color});
            if (plot.plot_valid && plot.plot_ready) begin
                chk("pixel_queued", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pixel", 32'({plot.plot_x, plot.plot_y, plot.plot_color}), 32'({XW'(e.x), YW'(e.y), CW'(e.c)}));
                end
            end
        end
        chk("frame_done_count", dones, 1);
        chk("overrun_count", ovrs, int'(poke));
        chk("pixels_left", exp_q.size(), 0);
        if (!rnd) chk("frame_length", done_k, m_len);
        exp_q.delete();
        frame_tick = 1'b0;
        plot.plot_ready = 1'b1;
    endtask

    initial begin
        plot.plot_ready = 1'b1;
        for (int o = 0; o < N; o++) begin
            m_act[o] = 0;
            m_x[o] = 0;
            m_y[o] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(plot.plot_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_cur_obj", 32'(cur_obj), 0);
        chk("rst_pixel", 32'({plot.plot_x, plot.plot_y, plot.plot_color}), 0);
        reset = 1'b0;
        @(negedge clk);

        obj_active = 6'b000001;
        set_obj(0, 10, 20, 3);
        run_frame(1'b0, 1'b0);
        obj_active = 6'b000001;
        set_obj(0, 11, 20, 3);
        run_frame(1'b0, 1'b0);
        obj_active = 6'b000001;
        set_obj(0, 11, 20, 3);
        run_frame(1'b1, 1'b0);
        randomize_objs();
        run_frame(1'b0, 1'b1);
        obj_active = 6'b000011;
        set_obj(0, 156, 118, 6);
        set_obj(1, 252, 125, 2);
        run_frame(1'b0, 1'b0);

        obj_active = 6'b000001;
        set_obj(0, 40, 50, 5);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (69) @(negedge clk);
        chk("in_draw_before_reset", 32'({plot.plot_valid, plot.plot_color}), 32'({1'b1, 3'd5}));
        #2 reset = 1'b1;
        #1;
        chk("async_reset_valid", 32'(plot.plot_valid), 0);
        chk("async_reset_busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int o = 0; o < N; o++) m_act[o] = 0;
        randomize_objs();
        obj_active[0] = 1'b1;
        run_frame(1'b0, 1'b0);

        for (int f = 0; f < 4; f++) begin
            randomize_objs();
            run_frame(f % 2 == 1, f >= 2);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_draw_scheduler.md
# sprite_draw_scheduler

Per-frame scheduler that shares the single pixel-plot port of the VGA adapter among all on-screen objects (player, enemies, bullet). On each frame tick it snapshots the object table, then for every object in index order erases the sprite at its previous-frame position and draws it at its new position, emitting one pixel per accepted valid/ready handshake. It sits between the game-state logic, which owns positions, and the VGA adapter's plot interface.

## Interface
- NUM_OBJ, 6: number of objects; index 0 = player.
- SPR_W, 8: sprite width in pixels.
- SPR_H, 8: sprite height in pixels.
- X_W, 8: x-coordinate width.
- Y_W, 7: y-coordinate width.
- COLOR_W, 3: colour width.
- SCREEN_W, 160: visible width; used only with clipping.
- SCREEN_H, 120: visible height; used only with clipping.
- BG_COLOR, 0: erase colour.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse that starts a frame.
- obj_active  in  NUM_OBJ  per-object visible flag.
- obj_x  in  NUM_OBJ*X_W  packed x positions; object i is at [i*X_W +: X_W].
- obj_y  in  NUM_OBJ*Y_W  packed y positions.
- obj_color  in  NUM_OBJ*COLOR_W  packed colours.
- plot_ready  in  1  VGA adapter accepts a pixel this cycle.
- plot_valid  out  1  pixel present.
- plot_x  out  X_W  pixel x.
- plot_y  out  Y_W  pixel y.
- plot_color  out  COLOR_W  pixel colour.
- cur_obj  out  4  index of the object being serviced.
- busy  out  1  high from the cycle after an accepted tick until the frame completes.
- frame_done  out  1  one-cycle pulse when the frame completes.
- overrun  out  1  one-cycle pulse when a tick arrives while busy.

## Operation
- States: IDLE, SELECT, ERASE, DRAW, NEXT, DONE.
- IDLE + frame_tick:
  - Snapshot obj_active, obj_x, obj_y and obj_color into shadow registers.
  - Set i=0 and go to SELECT.
- SELECT(i):
  - Go to ERASE if prev_active[i].
  - Otherwise go to DRAW if snap_active[i].
  - Otherwise go to NEXT.
- ERASE:
  - Raster scan of SPR_W×SPR_H at (prev_x[i]+px, prev_y[i]+py) with BG_COLOR.
  - px increments fastest.
  - On acceptance of the final pixel, go to DRAW if snap_active[i], else go to NEXT.
- DRAW: same scan at the snapshot position with snap_color[i]; after the final pixel, go to NEXT.
- NEXT:
  - Commit prev_active/x/y[i] from the snapshot.
  - If i==NUM_OBJ-1, go to DONE; otherwise increment i and go to SELECT.
- DONE: pulse frame_done, then return to IDLE.
- Handshake:
  - plot_x, plot_y and plot_color are stable while plot_valid is high and plot_ready is low.
  - px/py advance only on plot_valid && plot_ready.
- Coordinates are base+offset truncated to X_W/Y_W, so they wrap modulo 2^width unless clipping is compiled in.
- frame_tick while not IDLE: ignored and overrun pulses; the snapshot is unchanged.
- Input changes after the snapshot have no effect until the next frame.
- Reset values:
  - State IDLE; prev_active all 0, so the first frame performs no erase.
  - All outputs 0.

## Timing
- Tick sampled at edge T: busy=1 and state=SELECT from T+1.
- First plot_valid at T+2 if object 0 needs work.
- Each SELECT and each NEXT costs one cycle.
- Each scan costs SPR_W*SPR_H accepted handshakes, with no bubbles between pixels when plot_ready is held high.
- With ready held high, frame length (ticks to frame_done) is 2*NUM_OBJ + 1 + (erases + draws)*SPR_W*SPR_H cycles.
- frame_done is high for the DONE cycle; busy drops in the same cycle.
- Asynchronous reset mid-frame:
  - Immediately returns to IDLE and deasserts plot_valid.
  - Clears prev_active, so stale pixels remain on screen until overdrawn.

## Configuration
- DRAW_CLIP_EN defined:
  - A pixel with unwrapped x ≥ SCREEN_W or y ≥ SCREEN_H is suppressed: plot_valid stays low and the counter advances in one cycle.
  - Computation uses X_W+1 / Y_W+1 bit sums.
- DRAW_CLIP_EN undefined: no suppression; coordinates wrap.

## Structure
- Shared package draw_pkg holds:
  - The state enum.
  - The OBJ_IDX_W=4 constant.
  - Default SPR_W, SPR_H, SCREEN_W, SCREEN_H and BG_COLOR.
- Sub-module sprite_pixel_scanner:
  - Inputs: base x/y, colour and start.
  - Runs the px/py counters with the valid/ready handshake.
  - Applies clipping when enabled.
  - Pulses last on acceptance of the final pixel.
- The scheduler FSM, shadow registers and prev table stay at top level.

## Test plan
- After reset, tick with only obj 0 active at (10,20), colour 3, ready=1:
  - Exactly 64 pixels, x 10–17 and y 20–27, all colour 3.
  - No erase pixels.
  - frame_done at 2*6+1+64=77 cycles after the tick.
- Second tick with obj 0 at (11,20):
  - 64 BG pixels at (10..17, 20..27), then 64 colour-3 pixels at (11..18, 20..27).
- Toggle plot_ready 1/0 randomly:
  - Outputs are held during stalls.
  - Pixel sequence is identical to the ready=1 run.
  - No pixel is dropped or duplicated.
- Tick while busy: overrun pulses once; the frame's pixels match an undisturbed run; no extra frame_done.
- Obj at (156,118):
  - Without DRAW_CLIP_EN: wrap only past 255/127.
  - With DRAW_CLIP_EN: only x 156–159, y 118–119 plotted (8 pixels).
- Assert reset mid-DRAW: plot_valid 0 immediately; the next frame performs no erases.
